// File: rtl/gearbox_pkg.sv
// Shared constants and types for the 66b->64b transmit gearbox.
// The period and sequence-counter width follow from the payload and header widths.
package gearbox_pkg;

  localparam int GB_DATA_W = 64;
  localparam int GB_HEAD_W = 2;

  // One extra cycle per period drains the accumulated header bits.
  function automatic int gb_period(input int data_w, input int head_w);
    return data_w / head_w + 1;
  endfunction

  localparam int P     = gb_period(GB_DATA_W, GB_HEAD_W);
  localparam int SEQ_W = $clog2(P);

  typedef logic [SEQ_W-1:0] seq_t;

endpackage

// File: rtl/gearbox_tx_if.sv
// Upstream block / downstream SERDES bundle for gearbox_tx.
// Handshake: the upstream presents one block (valid_i) on every cycle where
// full_o is low; on a cycle where full_o is high, data_i is ignored and the
// upstream must hold off. full_o is decoded combinationally from the sequence
// register, so it is valid for the whole cycle it applies to.
interface gearbox_tx_if #(
  parameter int LANE_N = 4,
  parameter int DATA_W = 64,
  parameter int HEAD_W = 2
);
  localparam int BLOCK_W = DATA_W + HEAD_W;

  logic                       valid_i;
  logic [LANE_N*BLOCK_W-1:0]  data_i;
  logic                       full_o;
  logic [LANE_N*DATA_W-1:0]   data_o;

  modport master (output valid_i, output data_i, input full_o, input data_o);
  modport slave  (input valid_i, input data_i, output full_o, output data_o);

endinterface

// File: rtl/gearbox_tx_lane.sv
// Per-lane gearbox datapath: residue register plus registered SERDES word.
// res_q holds HEAD_W*seq valid low bits; all higher bits are kept zero so the
// residue can simply be OR-ed under the shifted payload.
module gearbox_tx_lane
  import gearbox_pkg::*;
#(
  parameter int HEAD_W  = GB_HEAD_W,
  parameter int DATA_W  = GB_DATA_W,
  parameter int BLOCK_W = DATA_W + HEAD_W
) (
  input  logic               clk,
  input  logic               nreset,
  input  seq_t               seq,
  input  logic [BLOCK_W-1:0] block,
  output logic [DATA_W-1:0]  data
);

  localparam int   SHW      = $clog2(DATA_W + 1);
  localparam seq_t SEQ_LAST = seq_t'(P - 1);

  logic [DATA_W-1:0]  res_q;
  logic [DATA_W-1:0]  res_d;
  logic [DATA_W-1:0]  data_d;
  logic [BLOCK_W-1:0] hi_bits;
  logic [SHW-1:0]     lo_sh;
  logic [SHW-1:0]     hi_sh;

  // Next word/residue: splice payload above the residue, or drain the residue.
  always_comb begin
    lo_sh   = SHW'(HEAD_W * int'(seq));
    hi_sh   = SHW'(DATA_W - HEAD_W * int'(seq));
    data_d  = res_q;
    res_d   = '0;
    hi_bits = '0;
    if (seq != SEQ_LAST) begin
      data_d  = (block[DATA_W-1:0] << lo_sh) | res_q;
      hi_bits = block >> hi_sh;
      res_d   = hi_bits[DATA_W-1:0];
    end
  end

  // Residue and output word registers; reset discards any partial residue.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      res_q <= '0;
      data  <= '0;
    end else begin
      res_q <= res_d;
      data  <= data_d;
    end
  end

endmodule

// File: rtl/gearbox_tx.sv
// Transmit gearbox top: 66-bit PCS blocks in, 64-bit SERDES words out.
// One shared sequence counter drives every lane, so all lanes stall together.
// Optional feature macro: GEARBOX_TX_ERR_EN adds err_o, a sticky flag for
// overrun (valid_i during full_o) and underrun (missing block once started).
module gearbox_tx
  import gearbox_pkg::*;
#(
  parameter int LANE_N  = 4,
  parameter int HEAD_W  = GB_HEAD_W,
  parameter int DATA_W  = GB_DATA_W,
  parameter int BLOCK_W = DATA_W + HEAD_W
) (
  input  logic         clk,
  input  logic         nreset,
  gearbox_tx_if.slave  bus
`ifdef GEARBOX_TX_ERR_EN
  ,
  output logic         err_o
`endif
);

  localparam seq_t SEQ_LAST = seq_t'(P - 1);

  seq_t                     seq_q;
  logic                     full;
  logic [LANE_N*DATA_W-1:0] data_all;

  // Free-running period counter 0..P-1, independent of valid_i.
  always_ff @(posedge clk) begin
    if (!nreset)                seq_q <= '0;
    else if (seq_q == SEQ_LAST) seq_q <= '0;
    else                        seq_q <= seq_q + seq_t'(1);
  end

  assign full       = (seq_q == SEQ_LAST);
  assign bus.full_o = full;
  assign bus.data_o = data_all;

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    gearbox_tx_lane #(
      .HEAD_W  (HEAD_W),
      .DATA_W  (DATA_W),
      .BLOCK_W (BLOCK_W)
    ) u_lane (
      .clk    (clk),
      .nreset (nreset),
      .seq    (seq_q),
      .block  (bus.data_i[l*BLOCK_W +: BLOCK_W]),
      .data   (data_all[l*DATA_W +: DATA_W])
    );
  end

`ifdef GEARBOX_TX_ERR_EN
  logic started_q;
  logic err_q;

  // Sticky protocol checker; underrun only counts after the first block.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      started_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (bus.valid_i) started_q <= 1'b1;
      if ((bus.valid_i && full) || (!bus.valid_i && !full && started_q))
        err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_valid;
  assign unused_valid = bus.valid_i;
`endif

endmodule
